// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: format codes,
// RV opcodes and the skid-buffer occupancy encoding.
package imm_gen_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned OPC_W  = 7;

  // Format codes presented on o_fmt
  localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
  localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

  // Major opcodes recognised by the decoder
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Occupancy of the main/skid pair
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: derives the format from the opcode and
// builds the sign-extended immediate (always extended from inst[31]).
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [FMT_W-1:0]  fmt,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_sel;

  // Raw 32-bit immediates for every format; selection happens below
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Opcode to format selection; unknown opcodes yield zero and flag illegal
  always_comb begin
    fmt     = FMT_ILL;
    imm_sel = '0;
    illegal = 1'b1;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt     = FMT_I;
        imm_sel = imm_i;
        illegal = 1'b0;
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        imm_sel = imm_s;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        fmt     = FMT_B;
        imm_sel = imm_b;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt     = FMT_U;
        imm_sel = imm_u;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        fmt     = FMT_J;
        imm_sel = imm_j;
        illegal = 1'b0;
      end
      OPC_OP: begin
        fmt     = FMT_R;
        imm_sel = '0;
        illegal = 1'b0;
      end
      default: begin
        fmt     = FMT_ILL;
        imm_sel = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; the signed source makes the cast sign-extend for RV64
  assign imm = XLEN'(imm_sel);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator with a 2-entry skid so o_ready
// can be a flop while sustaining one instruction per cycle.
// Optional feature macro: IMM_TARGET_EN adds o_target = o_pc + o_immediate.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INST_W-1:0] i_instruction,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_immediate,
  output logic [FMT_W-1:0]  o_fmt,
  output logic              o_illegal,
  output logic [PC_W-1:0]   o_pc
`ifdef IMM_TARGET_EN
  ,
  output logic [PC_W-1:0]   o_target
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
    logic [PC_W-1:0]  pc;
`ifdef IMM_TARGET_EN
    logic [PC_W-1:0]  target;
`endif
  } entry_t;

  entry_t     in_e;
  entry_t     main_q;
  entry_t     skid_q;
  state_e     state_q;
  logic       valid_q;
  logic       ready_q;
  logic       accept;
  logic       emit;

  logic [FMT_W-1:0] dec_fmt;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .inst    (i_instruction),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Pack the decoded fields (and the branch/jump target) for storage
  always_comb begin
    in_e         = '0;
    in_e.imm     = dec_imm;
    in_e.fmt     = dec_fmt;
    in_e.illegal = dec_illegal;
    in_e.pc      = i_pc;
`ifdef IMM_TARGET_EN
    in_e.target  = i_pc + PC_W'(dec_imm);
`endif
  end

  assign accept = i_valid && ready_q;
  assign emit   = valid_q && i_ready;

  // Occupancy FSM plus main/skid storage; flush overrides every other event
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (i_flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_e;
            state_q <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_e;
          end else if (accept) begin
            skid_q  <= in_e;
            state_q <= TWO;
            ready_q <= 1'b0;
          end else if (emit) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          // No accept is possible here because o_ready is low
          if (emit) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_immediate = main_q.imm;
  assign o_fmt       = main_q.fmt;
  assign o_illegal   = main_q.illegal;
  assign o_pc        = main_q.pc;
`ifdef IMM_TARGET_EN
  assign o_target    = main_q.target;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors on XLEN=32 and 64
// instances, stall/flush/reset scenarios and a randomized FIFO-model run.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;

  logic        valid, ready, o_ready, o_valid, o_illegal;
  logic [31:0] instr, pc, o_imm, o_pc;
  logic [2:0]  o_fmt;

  logic        valid64, ready64, o_ready64, o_valid64, o_illegal64;
  logic [31:0] instr64;
  logic [63:0] pc64, o_imm64, o_pc64;
  logic [2:0]  o_fmt64;

`ifdef IMM_TARGET_EN
  logic [31:0] o_target;
  logic [63:0] o_target64;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_instruction(instr), .i_pc(pc), .o_valid(o_valid), .i_ready(ready),
    .o_immediate(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal), .o_pc(o_pc)
`ifdef IMM_TARGET_EN
    , .o_target(o_target)
`endif
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid64), .o_ready(o_ready64),
    .i_instruction(instr64), .i_pc(pc64), .o_valid(o_valid64), .i_ready(ready64),
    .o_immediate(o_imm64), .o_fmt(o_fmt64), .o_illegal(o_illegal64), .o_pc(o_pc64)
`ifdef IMM_TARGET_EN
    , .o_target(o_target64)
`endif
  );

  // Reference decode: immediate as a signed integer value, then scaled
  function automatic void ref_decode(input logic [31:0] inst, output logic [63:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    longint v;
    v   = 0;
    ill = 1'b0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1; v = $signed(inst[31:20]);
      end
      7'b0100011: begin
        fmt = 3'd2; v = $signed({inst[31:25], inst[11:7]});
      end
      7'b1100011: begin
        fmt = 3'd3; v = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}); v = v * 2;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4; v = $signed(inst[31:12]); v = v * 4096;
      end
      7'b1101111: begin
        fmt = 3'd5; v = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}); v = v * 2;
      end
      7'b0110011: begin
        fmt = 3'd0; v = 0;
      end
      default: begin
        fmt = 3'd7; ill = 1'b1; v = 0;
      end
    endcase
    imm = v;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    logic [6:0]  op;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000, 7'b1111111};
    r  = $urandom();
    op = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) op = r[6:0];
    return {r[31:7], op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    valid = 1'b0; ready = 1'b0; instr = '0; pc = '0;
    valid64 = 1'b0; ready64 = 1'b1; instr64 = '0; pc64 = '0;
    #12;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
    checks++; if ({o_imm, o_fmt, o_illegal, o_pc} !== '0) begin errors++; $display("FAIL reset_data: imm %h fmt %0d ill %b pc %h exp 0", o_imm, o_fmt, o_illegal, o_pc); end
    checks++; if ({o_valid64, o_imm64, o_pc64} !== '0) begin errors++; $display("FAIL reset_data64: v %b imm %h pc %h exp 0", o_valid64, o_imm64, o_pc64); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vectors32();
    logic [31:0] insts [4];
    logic [31:0] exp_imm [4];
    logic [2:0]  exp_fmt [4];
    insts   = '{32'hFFF00093, 32'hFE000EE3, 32'h0010006F, 32'h123452B7};
    exp_imm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000};
    exp_fmt = '{3'd1, 3'd3, 3'd5, 3'd4};
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; instr = insts[i]; pc = 32'h2000 + 32'(i * 4);
      tick();
      valid = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_imm !== exp_imm[i] || o_fmt !== exp_fmt[i] || o_illegal !== 1'b0)
        begin errors++; $display("FAIL vec32_%0d: v %b imm %h fmt %0d ill %b exp imm %h fmt %0d", i, o_valid, o_imm, o_fmt, o_illegal, exp_imm[i], exp_fmt[i]); end
      checks++; if (o_pc !== 32'h2000 + 32'(i * 4)) begin errors++; $display("FAIL vec32_pc_%0d: got %h exp %h", i, o_pc, 32'h2000 + 32'(i * 4)); end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL vec32_drain_%0d: got %b exp 0", i, o_valid); end
    end
  endtask

  task automatic test_vectors64();
    logic [31:0] insts [3];
    logic [63:0] exp_imm [3];
    logic [2:0]  exp_fmt [3];
    logic        exp_ill [3];
    insts   = '{32'h800002B7, 32'h0000007F, 32'hFFF00093};
    exp_imm = '{64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFF};
    exp_fmt = '{3'd4, 3'd7, 3'd1};
    exp_ill = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      valid64 = 1'b1; instr64 = insts[i]; pc64 = 64'h8000_0000_0000_0000 + 64'(i);
      tick();
      valid64 = 1'b0;
      checks++; if (o_valid64 !== 1'b1 || o_imm64 !== exp_imm[i] || o_fmt64 !== exp_fmt[i] || o_illegal64 !== exp_ill[i])
        begin errors++; $display("FAIL vec64_%0d: v %b imm %h fmt %0d ill %b exp imm %h fmt %0d ill %b", i, o_valid64, o_imm64, o_fmt64, o_illegal64, exp_imm[i], exp_fmt[i], exp_ill[i]); end
      tick();
    end
  endtask

  task automatic test_stall();
    // A=addi 1, B=addi 2, C=addi 3 so order is visible on o_immediate
    ready = 1'b0;
    valid = 1'b1; instr = 32'h00100093; pc = 32'h100;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_ready0: got %b exp 1", o_ready); end
    tick();
    instr = 32'h00200093; pc = 32'h104;
    checks++; if (o_valid !== 1'b1 || o_imm !== 32'd1 || o_ready !== 1'b1) begin errors++; $display("FAIL stall_c1: v %b imm %h rdy %b exp 1/1/1", o_valid, o_imm, o_ready); end
    tick();
    instr = 32'h00300093; pc = 32'h108;
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_imm !== 32'd1 || o_pc !== 32'h100)
        begin errors++; $display("FAIL stall_hold_%0d: rdy %b v %b imm %h pc %h exp 0/1/1/100", k, o_ready, o_valid, o_imm, o_pc); end
      tick();
    end
    ready = 1'b1;
    checks++; if (o_valid !== 1'b1 || o_imm !== 32'd1) begin errors++; $display("FAIL stall_outA: v %b imm %h exp 1/1", o_valid, o_imm); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_imm !== 32'd2 || o_pc !== 32'h104 || o_ready !== 1'b1) begin errors++; $display("FAIL stall_outB: v %b imm %h pc %h rdy %b exp 1/2/104/1", o_valid, o_imm, o_pc, o_ready); end
    tick();
    valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_imm !== 32'd3 || o_pc !== 32'h108) begin errors++; $display("FAIL stall_outC: v %b imm %h pc %h exp 1/3/108", o_valid, o_imm, o_pc); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b exp 0", o_valid); end
  endtask

  task automatic test_flush();
    ready = 1'b0;
    valid = 1'b1; instr = 32'h00100093; tick();
    instr = 32'h00200093; tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: rdy %b exp 0", o_ready); end
    flush = 1'b1; instr = 32'h00300093; tick();
    flush = 1'b0; valid = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL flush_two: v %b rdy %b exp 0/1", o_valid, o_ready); end
    ready = 1'b1; tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept: v %b exp 0", o_valid); end
    // Async reset in the middle of a held entry
    ready = 1'b0; valid = 1'b1; instr = 32'hFFF00093; pc = 32'h300; tick();
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_imm !== '0 || o_pc !== '0 || o_fmt !== '0)
      begin errors++; $display("FAIL async_reset: v %b rdy %b imm %h pc %h fmt %0d exp 0/1/0/0/0", o_valid, o_ready, o_imm, o_pc, o_fmt); end
    #1 rst_n = 1'b1;
    tick();
  endtask

`ifdef IMM_TARGET_EN
  task automatic test_target();
    ready = 1'b1;
    valid = 1'b1; instr = 32'hFE000EE3; pc = 32'h00001000; tick();
    checks++; if (o_target !== 32'h00000FFC) begin errors++; $display("FAIL target_beq: got %h exp 00000ffc", o_target); end
    instr = 32'h0080006F; pc = 32'hFFFFFFFC; tick();
    valid = 1'b0;
    checks++; if (o_target !== 32'h00000004) begin errors++; $display("FAIL target_wrap: got %h exp 00000004", o_target); end
    tick();
  endtask
`endif

  task automatic test_random();
    exp_t e;
    logic acc, emt;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      valid = ($urandom_range(0, 9) < 7);
      ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      instr = rand_inst();
      pc    = $urandom();
      checks++; if (o_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready c%0d: got %b exp %b", c, o_ready, q.size() < 2); end
      checks++; if (o_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid c%0d: got %b exp %b", c, o_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++;
        if (o_imm !== q[0].imm[31:0] || o_fmt !== q[0].fmt || o_illegal !== q[0].ill || o_pc !== q[0].pc)
          begin errors++; $display("FAIL rand_data c%0d: imm %h fmt %0d ill %b pc %h exp %h %0d %b %h", c, o_imm, o_fmt, o_illegal, o_pc, q[0].imm[31:0], q[0].fmt, q[0].ill, q[0].pc); end
`ifdef IMM_TARGET_EN
        checks++;
        if (o_target !== q[0].pc + q[0].imm[31:0]) begin errors++; $display("FAIL rand_target c%0d: got %h exp %h", c, o_target, q[0].pc + q[0].imm[31:0]); end
`endif
      end
      acc = valid && (q.size() < 2);
      emt = ready && (q.size() > 0);
      ref_decode(instr, e.imm, e.fmt, e.ill);
      e.pc = pc;
      tick();
      if (flush) q.delete();
      else begin
        if (emt) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    tick(); tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rand_drain: got %b exp 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_vectors32();
    test_vectors64();
    test_stall();
    test_flush();
`ifdef IMM_TARGET_EN
    test_target();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
